i2sm_tx_ctrl: RTL and testbench

Frame-level scheduler between the async sample FIFO read side and the I2S master transmitter, in the MCLK domain. Per frame request from the transmitter it fetches one stereo word, presents it with a one-cycle valid, and on underrun substitutes a defined sample. It gates playback start until the FIFO is primed to a threshold. It falls back to re-priming after sustained underruns, and reports status counters.

---
 rtl/i2sm_tx_ctrl.sv | 146 ++++++++++++++
 tb/tb_i2sm_tx_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/i2sm_tx_ctrl.sv
// Frame scheduler between the sample FIFO read side and the I2S master transmitter (MCLK domain).
// Optional macro UNDERRUN_HOLD_EN: on underrun repeat the last fetched sample instead of muting.
module i2sm_tx_ctrl #(
  parameter int DW           = 24,
  parameter int LW           = 10,
  parameter int START_LEVEL  = 256,
  parameter int MAX_UNDERRUN = 4,
  parameter int CW           = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            frame_req,
  output logic            fifo_rd_en,
  input  logic            fifo_empty,
  input  logic [LW-1:0]   fifo_level,
  input  logic [2*DW-1:0] fifo_rd_data,
  output logic            o_valid,
  output logic [DW-1:0]   l_sample,
  output logic [DW-1:0]   r_sample,
  output logic            running,
  output logic [CW-1:0]   underrun_cnt,
  output logic            req_overlap
);

  typedef enum logic [2:0] {IDLE, PRIME, RUN, RD, LATCH} state_t;

  localparam logic [LW:0]   START_LVL = START_LEVEL[LW:0];
  localparam logic [CW-1:0] MAX_CONSEC = MAX_UNDERRUN[CW-1:0];

  state_t state, next_state;
  logic fetch_start, underrun, zero_req, capture, reprime;
  logic via_rd;
  logic [CW-1:0] consec;
  logic d1_valid, d2_valid;
  logic [2*DW-1:0] d1_data, d2_data;
  logic [2*DW-1:0] sub_data;

`ifdef UNDERRUN_HOLD_EN
  logic [2*DW-1:0] hold_data;
  assign sub_data = hold_data;
`else
  assign sub_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Zero answers and underrun substitutes ride a 2-stage delay so every
  // frame_req sees its o_valid exactly three cycles later.
  always_comb begin
    next_state  = state;
    fetch_start = 1'b0;
    underrun    = 1'b0;
    zero_req    = 1'b0;
    capture     = 1'b0;
    reprime     = 1'b0;
    case (state)
      IDLE: begin
        zero_req = frame_req;
        if (enable) next_state = PRIME;
      end
      PRIME: begin
        zero_req = frame_req;
        if (!enable)                            next_state = IDLE;
        else if ({1'b0, fifo_level} >= START_LVL) next_state = RUN;
      end
      RUN: begin
        if (!enable) begin
          zero_req   = frame_req;
          next_state = IDLE;
        end else if (frame_req) begin
          if (!fifo_empty) begin
            fetch_start = 1'b1;
            next_state  = RD;
          end else begin
            underrun   = 1'b1;
            next_state = LATCH;
          end
        end
      end
      RD: next_state = LATCH;
      LATCH: begin
        capture = via_rd;
        if (!enable) next_state = IDLE;
        else if ((MAX_UNDERRUN != 0) && !via_rd && (consec >= MAX_CONSEC)) begin
          reprime    = 1'b1;
          next_state = PRIME;
        end else next_state = RUN;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_rd_en   <= 1'b0;
      via_rd       <= 1'b0;
      running      <= 1'b0;
      d1_valid     <= 1'b0;
      d1_data      <= '0;
      d2_valid     <= 1'b0;
      d2_data      <= '0;
      o_valid      <= 1'b0;
      l_sample     <= '0;
      r_sample     <= '0;
      underrun_cnt <= '0;
      consec       <= '0;
      req_overlap  <= 1'b0;
    end else begin
      fifo_rd_en <= fetch_start;
      via_rd     <= (state == RD);
      running    <= (next_state == RUN) || (next_state == RD) || (next_state == LATCH);
      d1_valid   <= zero_req | underrun;
      d1_data    <= underrun ? sub_data : '0;
      d2_valid   <= d1_valid;
      d2_data    <= d1_data;
      o_valid    <= capture | d2_valid;
      if (capture) begin
        l_sample <= fifo_rd_data[2*DW-1:DW];
        r_sample <= fifo_rd_data[DW-1:0];
      end else if (d2_valid) begin
        l_sample <= d2_data[2*DW-1:DW];
        r_sample <= d2_data[DW-1:0];
      end
      if (underrun) begin
        if (underrun_cnt != '1) underrun_cnt <= underrun_cnt + 1'b1;
        if (consec != '1)       consec       <= consec + 1'b1;
      end
      if (capture || reprime) consec <= '0;
      if (frame_req && ((state == RD) || (state == LATCH))) req_overlap <= 1'b1;
    end
  end

`ifdef UNDERRUN_HOLD_EN
  // Held sample restarts from silence whenever playback must re-prime.
  always_ff @(posedge clk) begin
    if (rst)                     hold_data <= '0;
    else if (capture)            hold_data <= fifo_rd_data;
    else if (next_state == PRIME) hold_data <= '0;
  end
`endif

endmodule

// File: tb/tb_i2sm_tx_ctrl.sv
// Randomized self-checking bench for i2sm_tx_ctrl against a frame-level reference model.
// Honours UNDERRUN_HOLD_EN the same way as the design.
module tb_i2sm_tx_ctrl;
  localparam int DW = 24, LW = 10, START = 256, MAXU = 4, CW = 16;
  localparam int NA = 8192;

  logic clk = 1'b0;
  logic rst, enable, frame_req, fifo_empty;
  logic [LW-1:0] fifo_level;
  logic [2*DW-1:0] fifo_rd_data;
  logic fifo_rd_en, o_valid, running, req_overlap;
  logic [DW-1:0] l_sample, r_sample;
  logic [CW-1:0] underrun_cnt;

  always #5 clk = ~clk;

  i2sm_tx_ctrl #(.DW(DW), .LW(LW), .START_LEVEL(START), .MAX_UNDERRUN(MAXU), .CW(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_req(frame_req),
    .fifo_rd_en(fifo_rd_en), .fifo_empty(fifo_empty), .fifo_level(fifo_level),
    .fifo_rd_data(fifo_rd_data), .o_valid(o_valid), .l_sample(l_sample),
    .r_sample(r_sample), .running(running), .underrun_cnt(underrun_cnt),
    .req_overlap(req_overlap)
  );

  int errors = 0, checks = 0, cyc = 0;

  // Reference model: playback mode, busy window of a frame in flight, and
  // per-cycle expected output events scheduled from each frame request.
  int mode = 0;  // 0 off, 1 priming, 2 playing
  int busy_until = -1, cap_cycle = -1, consec = 0, ucnt = 0;
  bit ovl = 0, rst_pend = 0;
  bit ev [NA];
  bit erd [NA];
  logic [DW-1:0] el [NA];
  logic [DW-1:0] er [NA];
  logic [DW-1:0] hl = '0, hr = '0, ml = '0, mr = '0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic model(input bit r, input bit en, input bit fr, input bit emp,
                       input int lvl, input logic [2*DW-1:0] data);
    int c;
    c = cyc;
    if (r) begin
      mode = 0; busy_until = -1; cap_cycle = -1; consec = 0; ucnt = 0; ovl = 0;
      hl = '0; hr = '0; rst_pend = 1;
      for (int k = 1; k <= 4; k++) begin ev[c+k] = 0; erd[c+k] = 0; end
      return;
    end
    if (c <= busy_until) begin
      if (fr) ovl = 1;
      if (c == cap_cycle) begin
        ev[c+1] = 1; el[c+1] = data[2*DW-1:DW]; er[c+1] = data[DW-1:0];
        hl = data[2*DW-1:DW]; hr = data[DW-1:0]; consec = 0;
      end
      if (c == busy_until) begin
        if (!en) mode = 0;
        else if (c != cap_cycle && MAXU != 0 && consec >= MAXU) begin
          mode = 1; consec = 0; hl = '0; hr = '0;
        end
      end
    end else if (mode == 2 && en) begin
      if (fr && !emp) begin
        erd[c+1] = 1; cap_cycle = c + 2; busy_until = c + 2;
      end else if (fr) begin
        if (ucnt < (1 << CW) - 1) ucnt++;
        consec++;
        busy_until = c + 1; cap_cycle = -1;
        ev[c+3] = 1;
`ifdef UNDERRUN_HOLD_EN
        el[c+3] = hl; er[c+3] = hr;
`else
        el[c+3] = '0; er[c+3] = '0;
`endif
      end
    end else begin
      if (fr) begin ev[c+3] = 1; el[c+3] = '0; er[c+3] = '0; end
      if (mode == 0) begin
        if (en) begin mode = 1; hl = '0; hr = '0; end
      end else if (mode == 1) begin
        if (!en) mode = 0;
        else if (lvl >= START) mode = 2;
      end else mode = 0;
    end
  endtask

  task automatic applyStimulus(input bit r, input bit en, input bit fr, input bit emp,
                               input int lvl, input logic [2*DW-1:0] data);
    @(posedge clk);
    #1;
    if (rst_pend) begin ml = '0; mr = '0; rst_pend = 0; end
    if (ev[cyc]) begin ml = el[cyc]; mr = er[cyc]; end
    checkOutput("o_valid", o_valid, ev[cyc]);
    checkOutput("fifo_rd_en", fifo_rd_en, erd[cyc]);
    checkOutput("l_sample", l_sample, ml);
    checkOutput("r_sample", r_sample, mr);
    checkOutput("running", running, mode == 2);
    checkOutput("underrun_cnt", underrun_cnt, ucnt);
    checkOutput("req_overlap", req_overlap, ovl);
    rst = r; enable = en; frame_req = fr; fifo_empty = emp;
    fifo_level = lvl[LW-1:0]; fifo_rd_data = data;
    model(r, en, fr, emp, lvl, data);
    cyc++;
  endtask

  localparam logic [2*DW-1:0] DATA_A = {24'h123456, 24'hABCDEF};

  task automatic step(input bit en, input bit fr, input bit emp, input int lvl, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, en, fr, emp, lvl, DATA_A);
  endtask

  initial begin
    logic [63:0] rnd;
    rst = 1'b1; enable = 1'b0; frame_req = 1'b0; fifo_empty = 1'b1;
    fifo_level = '0; fifo_rd_data = '0;
    repeat (2) @(posedge clk);
    // Priming threshold: 255 keeps priming with zero answers, 256 starts play
    step(0, 0, 0, 0, 2);
    step(1, 0, 0, 255, 3);
    step(1, 1, 0, 255, 1);
    step(1, 0, 0, 255, 5);
    step(1, 0, 0, 256, 2);
    // Normal fetch
    step(1, 1, 0, 300, 1);
    step(1, 0, 0, 300, 6);
    // Underruns: streak broken by a fetch after three, then four in a row
    for (int i = 0; i < 3; i++) begin step(1, 1, 1, 300, 1); step(1, 0, 1, 300, 4); end
    step(1, 1, 0, 300, 1); step(1, 0, 0, 300, 5);
    for (int i = 0; i < 4; i++) begin step(1, 1, 1, 300, 1); step(1, 0, 1, 300, 4); end
    step(1, 0, 0, 300, 3);
    // Back-to-back requests
    step(1, 1, 0, 300, 2);
    step(1, 0, 0, 300, 5);
    // Disable during fetch
    step(1, 1, 0, 300, 1);
    step(0, 0, 0, 300, 6);
    // Reset during fetch
    step(1, 0, 0, 300, 4);
    step(1, 1, 0, 300, 1);
    step(1, 0, 0, 300, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 300, DATA_A);
    step(0, 0, 0, 0, 5);
    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rnd = {$urandom(), $urandom()};
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 39) != 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                    int'($urandom_range(200, 320)), rnd[2*DW-1:0]);
    end
    step(0, 0, 0, 0, 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
